// File: rtl/unary_matmul_engine.sv
// unary_matmul_engine: DIMxDIM matrix multiply by counting coincident unary pulses, start/done handshake
module unary_matmul_engine #(
  parameter int DIM = 16,
  parameter int WIDTH = 4,
  parameter int SIGNED = 1,
  parameter int ACC_W = 2*WIDTH+$clog2(DIM)
)(
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    accumulate,
  input  logic [DIM-1:0][DIM-1:0][WIDTH-1:0]      in0,
  input  logic [DIM-1:0][DIM-1:0][WIDTH-1:0]      in1,
  output logic [DIM-1:0][DIM-1:0][ACC_W-1:0]      out,
  output logic                                    busy,
  output logic                                    done
);
  typedef enum logic [1:0] {IDLE, PREP, RUN, DONE} state_t;
  localparam logic [ACC_W-1:0] P1 = ACC_W'(1);
  localparam logic [ACC_W-1:0] M1 = '1;
  localparam logic [ACC_W-1:0] Z0 = '0;
  state_t r_state;
  logic [DIM-1:0][DIM-1:0][WIDTH-1:0] r_mag_a, r_mag_b;
  logic [DIM-1:0][DIM-1:0] r_sgn_a, r_sgn_b;
  logic [WIDTH-1:0] r_max_a, r_max_b, r_o, r_n, w_max_a, w_max_b;
  logic [DIM-1:0][DIM-1:0][ACC_W-1:0] r_out, w_next;
  logic r_busy, r_done;
  assign out = r_out;
  assign busy = r_busy;
  assign done = r_done;
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return (SIGNED != 0 && x[WIDTH-1]) ? -x : x;
  endfunction
  // each (i,k,j) term contributes one signed pulse while both unary streams are high
  always_comb begin
    w_max_a = '0;
    w_max_b = '0;
    for (int i = 0; i < DIM; i++)
      for (int k = 0; k < DIM; k++) begin
        w_max_a = r_mag_a[i][k] > w_max_a ? r_mag_a[i][k] : w_max_a;
        w_max_b = r_mag_b[i][k] > w_max_b ? r_mag_b[i][k] : w_max_b;
      end
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        w_next[i][j] = r_out[i][j];
        for (int k = 0; k < DIM; k++)
          w_next[i][j] = w_next[i][j] + ((r_o < r_mag_a[i][k] && r_n < r_mag_b[k][j]) ?
                         ((r_sgn_a[i][k] ^ r_sgn_b[k][j]) ? M1 : P1) : Z0);
      end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_sgn_a <= '0;
      r_sgn_b <= '0;
      r_max_a <= '0;
      r_max_b <= '0;
      r_o <= '0;
      r_n <= '0;
      r_out <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            for (int i = 0; i < DIM; i++)
              for (int k = 0; k < DIM; k++) begin
                r_mag_a[i][k] <= mag(in0[i][k]);
                r_mag_b[i][k] <= mag(in1[i][k]);
                r_sgn_a[i][k] <= SIGNED != 0 && in0[i][k][WIDTH-1];
                r_sgn_b[i][k] <= SIGNED != 0 && in1[i][k][WIDTH-1];
              end
            if (!accumulate) r_out <= '0;
            r_busy <= 1'b1;
            r_state <= PREP;
          end
        end
        PREP: begin
          r_max_a <= w_max_a;
          r_max_b <= w_max_b;
          r_o <= '0;
          r_n <= '0;
          if (w_max_a == '0 || w_max_b == '0) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_state <= DONE;
          end else r_state <= RUN;
        end
        RUN: begin
          r_out <= w_next;
          if (r_n == r_max_b - 1'b1) begin
            r_n <= '0;
            r_o <= r_o + 1'b1;
            if (r_o == r_max_a - 1'b1) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
              r_state <= DONE;
            end
          end else r_n <= r_n + 1'b1;
        end
        DONE: begin
          r_done <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_unary_matmul_engine.sv
// tb_unary_matmul_engine: table-driven scoreboard bench for the unary matrix multiplier (DIM=4, WIDTH=4, signed)
module tb_unary_matmul_engine;
  typedef logic [3:0][3:0][3:0] mat_t;
  typedef logic [3:0][3:0][9:0] res_t;
  typedef struct { mat_t a; mat_t b; bit acc; int lat; int glitch; } vec_t;
  typedef struct { res_t out; int lat; int busy_cyc; } exp_t;
  logic clk = 0, reset = 1, start = 0, accumulate = 0;
  mat_t in0 = '0, in1 = '0;
  res_t out;
  logic busy, done;
  int n_chk = 0, n_err = 0;
  res_t m_out = '0;
  exp_t sbq[$];
  vec_t tbl[10];
  vec_t v;

  unary_matmul_engine #(.DIM(4), .WIDTH(4), .SIGNED(1), .ACC_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .accumulate(accumulate),
    .in0(in0), .in1(in1), .out(out), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic res_t matmul(input mat_t a, input mat_t b, input res_t prior, input bit acc);
    res_t r;
    int s;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += int'($signed(a[i][k])) * int'($signed(b[k][j]));
        r[i][j] = (acc ? prior[i][j] : 10'd0) + 10'(s);
      end
    return r;
  endfunction

  function automatic int mg(input logic [3:0] x);
    return x[3] ? 16 - int'(x) : int'(x);
  endfunction

  function automatic int runlen(input mat_t a, input mat_t b);
    int ma = 0, mb = 0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma = mg(a[i][k]) > ma ? mg(a[i][k]) : ma;
        mb = mg(b[i][k]) > mb ? mg(b[i][k]) : mb;
      end
    return ma * mb;
  endfunction

  task automatic run(input vec_t t);
    exp_t e;
    int cyc, nb;
    e.out = matmul(t.a, t.b, m_out, t.acc);
    e.lat = t.lat;
    e.busy_cyc = runlen(t.a, t.b) + 1;
    m_out = e.out;
    sbq.push_back(e);
    in0 = t.a;
    in1 = t.b;
    accumulate = t.acc;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    in0 = mat_t'({$urandom, $urandom});
    in1 = mat_t'({$urandom, $urandom});
    accumulate = 1'($urandom);
    cyc = 1;
    nb = 0;
    while (!done && cyc < 200) begin
      if (busy) nb++;
      if (cyc == t.glitch) begin
        start = 1;
        accumulate = 0;
        in0 = '0;
      end else start = 0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 0;
    e = sbq.pop_front();
    check("done_latency", 160'(cyc), 160'(e.lat));
    check("out_matrix", out, e.out);
    check("busy_cycles", 160'(nb), 160'(e.busy_cyc));
    @(posedge clk); #1;
    check("done_one_cycle", 160'(done), 160'(0));
  endtask

  initial begin
    for (int t = 0; t < 10; t++) begin
      tbl[t].acc = 0;
      tbl[t].glitch = -1;
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < 4; k++) begin
          case (t)
            0: begin tbl[t].a[i][k] = (i == k) ? 4'd1 : 4'd0; tbl[t].b[i][k] = 4'(i + k); end
            1, 6: begin tbl[t].a[i][k] = 4'h8; tbl[t].b[i][k] = 4'd7; end
            2: begin tbl[t].a[i][k] = 4'd0; tbl[t].b[i][k] = 4'($urandom); end
            3, 4, 5: begin tbl[t].a[i][k] = (i == k) ? 4'd1 : 4'd0; tbl[t].b[i][k] = 4'd3; end
            default: begin tbl[t].a[i][k] = 4'($urandom); tbl[t].b[i][k] = 4'($urandom); end
          endcase
        end
    end
    tbl[0].lat = 8;
    tbl[1].lat = 58;
    tbl[2].lat = 2;
    tbl[3].lat = 5;
    tbl[4].lat = 5;
    tbl[4].acc = 1;
    tbl[5].lat = 5;
    tbl[6].lat = 58;
    tbl[6].glitch = 10;
    for (int t = 7; t < 10; t++) begin
      tbl[t].acc = 1'($urandom);
      tbl[t].lat = runlen(tbl[t].a, tbl[t].b) + 2;
    end
    reset = 1;
    start = 1;
    in0 = tbl[1].a;
    in1 = tbl[1].b;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", out, '0);
    check("reset_busy", 160'(busy), 160'(0));
    check("reset_done", 160'(done), 160'(0));
    reset = 0;
    start = 0;
    @(posedge clk); #1;
    check("no_accept_in_reset", 160'(busy), 160'(0));
    for (int t = 0; t < 10; t++) run(tbl[t]);
    in0 = tbl[1].a;
    in1 = tbl[1].b;
    accumulate = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (20) @(posedge clk);
    #1;
    check("busy_mid_run", 160'(busy), 160'(1));
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    m_out = '0;
    check("midrun_reset_out", out, '0);
    check("midrun_reset_busy", 160'(busy), 160'(0));
    repeat (3) @(posedge clk);
    #1;
    check("midrun_reset_idle", 160'({busy, done}), 160'(0));
    v = tbl[3];
    v.acc = 1;
    run(v);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/unary_matmul_engine.md
# unary_matmul_engine

Temporal (unary-stream) signed/unsigned matrix multiplier that computes a DIM×DIM product `out = in0 × in1` by counting coincident unary pulses, with a start/done handshake. It terminates early at the largest operand magnitudes and can accumulate onto the previous result for tiled multiplies. It is the parametrised next generation of the free-running unary multiplier in the matrix datapath.

## Interface
- `DIM`, 16, matrix dimension (≥2)
- `WIDTH`, 4, operand element width (≥2)
- `SIGNED`, 1, 1: operands are two's complement; 0: operands are unsigned
- `ACC_W`, 2*WIDTH+$clog2(DIM), result element width, two's complement
- `clk` input 1 — single clock, all logic on rising edge
- `reset` input 1 — synchronous, active-high
- `start` input 1 — request a multiply; accepted only in IDLE
- `accumulate` input 1 — sampled with accepted `start`; 1 = add onto current `out`, 0 = clear first
- `in0` input [DIM-1:0][DIM-1:0][WIDTH-1:0] — matrix A, element `in0[i][k]`; sampled on accept
- `in1` input [DIM-1:0][DIM-1:0][WIDTH-1:0] — matrix B, element `in1[k][j]`; sampled on accept
- `out` output [DIM-1:0][DIM-1:0][ACC_W-1:0] — result C, `out[i][j]`
- `busy` output 1 — high in PREP and RUN
- `done` output 1 — one-cycle pulse when `out` is final

## Operation
- States: IDLE, PREP, RUN, DONE.
- IDLE: `start`=1 → operands registered as magnitude `|x|` and sign bit (sign=0 when SIGNED=0); if `accumulate`=0, all `out` cleared on the same edge; → PREP. `start` outside IDLE is ignored (no queuing).
- Magnitude: SIGNED=1: |−2^(WIDTH−1)| = 2^(WIDTH−1); SIGNED=0: raw value. Magnitude registers are WIDTH bits wide.
- PREP (1 cycle): register maxA = max over all |A[i][k]|, maxB = max over all |B[k][j]|; outer counter o and inner counter n reset to 0. If maxA=0 or maxB=0 → DONE, else → RUN.
- RUN: each cycle, for every (i,j): delta = Σ_k s_ik·[o<|A[i][k]|]·[n<|B[k][j]|], where s_ik = −1 if sign(A[i][k])⊕sign(B[k][j]), else +1; `out[i][j]` += delta (sign-extended to ACC_W).
- Counter step: n increments; at n=maxB−1, n←0 and o increments; at o=maxA−1 and n=maxB−1 (last RUN cycle) → DONE.
- RUN length N = maxA·maxB cycles; final value = Σ_k A[i][k]·B[k][j] (+ prior `out` when accumulating).
- DONE (1 cycle): `done`=1, `busy`=0; → IDLE.
- `out` is held unchanged outside RUN and the clearing accept edge; it stays valid until the next accepted `start`.
- Arithmetic wraps modulo 2^ACC_W; no saturation, no overflow flag.
- `reset` (any state, including mid-RUN): state→IDLE, all `out`=0, `busy`=0, `done`=0, counters/maxima/operands=0; the partial result is discarded.

## Timing
- Reset values: `out`=0, `busy`=0, `done`=0.
- With `start` accepted in cycle T: PREP in T+1; RUN in T+2 … T+1+N; `done`=1 in cycle T+2+N. For N=0, `done` is in T+2.
- `busy`=1 for cycles T+1 … T+1+N.
- Earliest next accept: T+3+N (IDLE).
- `in0`/`in1`/`accumulate` may change freely after the accept cycle.
- `out` is updated at the edge ending each RUN cycle; the value seen while `done`=1 is final.

## Test plan
- Reset: assert `reset` 2 cycles with `start`=1 → `out` all 0, `busy`=0, `done`=0; no accept while `reset`=1.
- Identity, SIGNED=0, DIM=4, WIDTH=4: A=I, B[k][j]=k+j → `out`=B, maxA=1, maxB=6, `done` at T+8.
- Signed extreme, DIM=4, WIDTH=4: all A=−8, all B=7 → every `out`=−224 (ACC_W=10, value 0x320), N=56, `done` at T+58; `busy` high for exactly 57 cycles.
- Zero operand: A=0, B random, `accumulate`=0 after a previous nonzero result → `out` all 0, `done` at T+2.
- Accumulate: run A=I, B=all 3, then repeat with `accumulate`=1 → `out` all 6. Repeat a run with `accumulate`=0 → `out` all 3.
- Control corners: pulse `start` mid-RUN → ignored, result and `done` timing unchanged. Assert `reset` mid-RUN → IDLE, `out`=0. A fresh `start` then completes correctly.
